// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sseg_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

  localparam logic [6:0] SSEG_BLANK = 7'h7F;
  localparam int         MAX_DIGITS = 8;
endpackage

// File: rtl/sseg_scan_controller_hex.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_7_segment (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    unique case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/sseg_scan_controller.sv
// Multiplexed common-anode display scanner with blanking gaps, frame-synchronous
// value updates and leading-zero suppression.
module sseg_scan_controller
  import sseg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] value_i,
  input  logic [DIGITS-1:0]   dp_i,
  input  logic                lzs_en_i,
  output logic [DIGITS-1:0]   an_o,
  output logic [6:0]          sseg_o,
  output logic                dp_o,
  output logic                frame_o,
  output logic                pending_o
);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > MAX_DIGITS || REFRESH_DIV < 1 || BLANK_CYCLES < 1) begin : g_bad_param
    $error("sseg_scan_controller: illegal parameter value");
  end

  state_e              state, state_n;
  logic [IW-1:0]       idx, idx_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [4*DIGITS-1:0] disp, stg;
  logic [DIGITS-1:0]   disp_dp, stg_dp;
  logic                wrap, apply;
  logic [DIGITS-1:0]   an_n, zero_above;
  logic [6:0]          sseg_n, dec;
  logic [3:0]          nib;
  logic                dp_n, frame_n;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    wrap    = 1'b0;
    if (!enable_i) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = BLANK;
          idx_n   = '0;
          cnt_n   = CW'(BLANK_CYCLES - 1);
        end
        BLANK: begin
          if (cnt == '0) begin
            state_n = DRIVE;
            cnt_n   = CW'(REFRESH_DIV - 1);
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            state_n = BLANK;
            cnt_n   = CW'(BLANK_CYCLES - 1);
            if (idx == LAST) begin
              idx_n = '0;
              wrap  = 1'b1;
            end else begin
              idx_n = idx + IW'(1);
            end
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // While idle the display follows staging with one cycle of lag; while
  // scanning it only moves at the frame boundary so a frame never tears.
  assign apply = (state == IDLE) || wrap;

  // zero_above[k]: nibbles DIGITS-1..k of the display register are all zero
  always_comb begin
    zero_above = '0;
    for (int k = 0; k < DIGITS; k++)
      zero_above[k] = ((disp >> (4 * k)) == '0);
  end

  assign nib = disp[idx_n*4 +: 4];

  hex_to_7_segment u_dec (
    .hex (nib),
    .seg (dec)
  );

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    an_n    = '1;
    sseg_n  = SSEG_BLANK;
    dp_n    = 1'b1;
    frame_n = 1'b0;
    if (state_n == DRIVE) begin
      an_n    = ~(DIGITS'(1) << idx_n);
      sseg_n  = (lzs_en_i && idx_n != '0 && zero_above[idx_n]) ? SSEG_BLANK : dec;
      dp_n    = ~disp_dp[idx_n];
      frame_n = (idx_n == LAST) && (cnt_n == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      disp      <= '0;
      disp_dp   <= '0;
      stg       <= '0;
      stg_dp    <= '0;
      pending_o <= 1'b0;
      an_o      <= '1;
      sseg_o    <= SSEG_BLANK;
      dp_o      <= 1'b1;
      frame_o   <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      an_o    <= an_n;
      sseg_o  <= sseg_n;
      dp_o    <= dp_n;
      frame_o <= frame_n;
      if (apply) begin
        disp    <= stg;
        disp_dp <= stg_dp;
      end
      // a load on the apply cycle lands in staging after the older value moves out
      if (load_i) begin
        stg       <= value_i;
        stg_dp    <= dp_i;
        pending_o <= 1'b1;
      end else if (apply) begin
        pending_o <= 1'b0;
      end
    end
  end
endmodule
